uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised successor to the fixed-format UART receiver used by the RISC-V multicycle system, and the serial-input block for its memory-mapped UART peripheral. Supports configurable baud divisor, data width, parity mode and stop-bit count. Reports parity, framing, overrun and break conditions. Delivers each received word through a valid/ack holding register, so software can poll for data without losing it.

Parameters:
CLKS_PER_BIT, 434, clk cycles per serial bit (434 = 115200 baud at 50 MHz); minimum 4
DATA_BITS, 8, payload width, legal 5..9
PARITY_EN, 1, 1 = parity bit follows data, 0 = no parity bit
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0
STOP_BITS, 1, number of stop bits checked, 1 or 2

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
rx  input  1  serial line, idle high, asynchronous to clk
rx_ack  input  1  consumer pulse; clears rx_valid and the sticky error flags
rx_data  output  DATA_BITS  last received word, LSB = first bit on the line
rx_valid  output  1  high while rx_data holds an unconsumed word
parity_err  output  1  parity mismatch on the word in rx_data
frame_err  output  1  a stop bit sampled 0 on the word in rx_data
break_det  output  1  frame_err with all data bits 0 and parity bit 0
overrun_err  output  1  sticky; a word completed while rx_valid was already high
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, rst = 1): state IDLE, counters 0, both synchroniser flops = 1, all outputs 0.
- rx passes through a 2-flop synchroniser before use; every reference to "rx" below means the synchronised value.
- Bit counter runs 0..CLKS_PER_BIT-1. Mid-bit sample point is count = CLKS_PER_BIT/2 (integer division).
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: rx = 0 -> START with count cleared.
- START: at mid-bit, rx = 0 -> DATA; rx = 1 -> IDLE (false start; no flags, no output change). After the mid-bit sample, counting continues at full CLKS_PER_BIT intervals.
- DATA: samples DATA_BITS bits, one per CLKS_PER_BIT, LSB first, into a shift register. After the last bit: PARITY if PARITY_EN = 1, otherwise STOP.
- PARITY: one sample. Error = (XOR of data bits ^ parity bit ^ PARITY_ODD) != 0.
- STOP: STOP_BITS samples. Any stop sample of 0 sets the local frame error. On the last stop sample the frame completes and the state returns to IDLE immediately, at mid-bit, so back-to-back frames resynchronise.
- Completion, applied on the cycle after the final stop sample (atomic update):
  - rx_data <= shift register.
  - parity_err and frame_err <= local results; break_det <= frame error & data = 0 & parity bit = 0.
  - If rx_valid was already 1: overrun_err <= 1 and the new word still overwrites rx_data.
  - rx_valid <= 1.
- Latency: rx_valid rises 2 clk after the synchronised rx is sampled at the mid-point of the last stop bit (1 cycle to register the sample, 1 cycle for the output update), plus the 2-cycle synchroniser delay.
- rx_ack = 1 with no completion in the same cycle: rx_valid, parity_err, frame_err, break_det and overrun_err all clear to 0.
- rx_ack coinciding with a completion: completion wins. The new word and its flags load, rx_valid = 1, and overrun_err is NOT set.
- rx_ack while rx_valid = 0: no effect.
- rx_ack does not affect reception in progress.
- rx held low indefinitely: each frame ends with frame_err = 1 and break_det = 1. The receiver then re-enters START immediately and repeats one break report per frame time until rx returns high.
- rst asserted mid-frame: aborts the frame immediately, reaching the reset state above. A partial frame is never reported.

Test Plan:
Common setup: CLKS_PER_BIT = 16, DATA_BITS = 8, PARITY_EN = 1, PARITY_ODD = 0, STOP_BITS = 1, clk period 20 ns.
1. Send 0xA5 with even parity bit 0 and stop bit 1 -> rx_valid = 1, rx_data = 0xA5, all error flags 0. rx_ack for 1 clk -> rx_valid = 0.
2. Send 0x3C with parity bit 1 (wrong) -> rx_data = 0x3C, parity_err = 1, frame_err = 0.
3. Send 0x55 with stop bit 0 -> frame_err = 1, break_det = 0. Then hold rx = 0 for 12 bit times -> frame with rx_data = 0x00, frame_err = 1, break_det = 1.
4. Send 0x11 then 0x22 back-to-back with no rx_ack -> rx_data = 0x22, overrun_err = 1. Then rx_ack -> rx_valid = 0, overrun_err = 0.
5. Pulse rx low for 5 clk (shorter than half a bit) -> busy rises then falls, rx_valid stays 0. Separately, assert rst at bit 4 of a frame -> all outputs 0, next clean frame 0xC3 received correctly.
6. Re-run with DATA_BITS = 7, PARITY_EN = 1, PARITY_ODD = 1, STOP_BITS = 2: send 0x41 with odd parity 1 and second stop bit 0 -> rx_data = 0x41, parity_err = 0, frame_err = 1.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, mid-bit sampling FSM,
// and a valid/ack holding register carrying parity, framing, break and overrun flags.
module uart_rx_param #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 1,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   input  logic                 rx_ack,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 break_det,
   output logic                 overrun_err,
   output logic                 busy
);

   localparam int                CNT_W  = $clog2(CLKS_PER_BIT);
   localparam int                IDX_W  = 4;
   localparam logic [CNT_W-1:0]  HALF_C = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0]  DLAST  = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0]  SLAST  = IDX_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t                 state_q;
   logic                   rx_meta_q, rx_sync_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [IDX_W-1:0]       idx_q;
   logic [DATA_BITS-1:0]   shift_q;
   logic                   par_q, ferr_q, done_q;

   logic [DATA_BITS-1:0]   data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   perr_q, perr_d;
   logic                   ferr_out_q, ferr_out_d;
   logic                   brk_q, brk_d;
   logic                   ovr_q, ovr_d;
   logic                   perr_calc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
      end
   end

   // The counter is re-zeroed at the start bit's mid-point, so every later
   // sample at LAST_C lands in the middle of its bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         ferr_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               cnt_q <= '0;
               if (!rx_sync_q) state_q <= S_START;
            end
            S_START: begin
               if (cnt_q == HALF_C) begin
                  cnt_q   <= '0;
                  idx_q   <= '0;
                  par_q   <= 1'b0;
                  ferr_q  <= 1'b0;
                  state_q <= rx_sync_q ? S_IDLE : S_DATA;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_DATA: begin
               if (cnt_q == LAST_C) begin
                  cnt_q   <= '0;
                  shift_q <= {rx_sync_q, shift_q[DATA_BITS-1:1]};
                  if (idx_q == DLAST) begin
                     idx_q   <= '0;
                     state_q <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_PARITY: begin
               if (cnt_q == LAST_C) begin
                  cnt_q   <= '0;
                  par_q   <= rx_sync_q;
                  state_q <= S_STOP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_STOP: begin
               if (cnt_q == LAST_C) begin
                  cnt_q <= '0;
                  if (!rx_sync_q) ferr_q <= 1'b1;
                  if (idx_q == SLAST) begin
                     idx_q   <= '0;
                     done_q  <= 1'b1;
                     state_q <= S_IDLE;
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign perr_calc = (PARITY_EN != 0) && ((^shift_q) ^ par_q ^ (PARITY_ODD != 0));

   // A completing frame takes priority over a same-cycle ack.
   always_comb begin
      data_d     = data_q;
      valid_d    = valid_q;
      perr_d     = perr_q;
      ferr_out_d = ferr_out_q;
      brk_d      = brk_q;
      ovr_d      = ovr_q;
      if (done_q) begin
         data_d     = shift_q;
         valid_d    = 1'b1;
         perr_d     = perr_calc;
         ferr_out_d = ferr_q;
         brk_d      = ferr_q && (shift_q == '0) && !par_q;
         ovr_d      = rx_ack ? 1'b0 : (ovr_q | valid_q);
      end else if (rx_ack && valid_q) begin
         valid_d    = 1'b0;
         perr_d     = 1'b0;
         ferr_out_d = 1'b0;
         brk_d      = 1'b0;
         ovr_d      = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q     <= '0;
         valid_q    <= 1'b0;
         perr_q     <= 1'b0;
         ferr_out_q <= 1'b0;
         brk_q      <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         data_q     <= data_d;
         valid_q    <= valid_d;
         perr_q     <= perr_d;
         ferr_out_q <= ferr_out_d;
         brk_q      <= brk_d;
         ovr_q      <= ovr_d;
      end
   end

   assign rx_data     = data_q;
   assign rx_valid    = valid_q;
   assign parity_err  = perr_q;
   assign frame_err   = ferr_out_q;
   assign break_det   = brk_q;
   assign overrun_err = ovr_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: table vectors, hand-written corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_uart_rx_param;
   localparam int CPB = 16;

   logic clk = 1'b0, rst = 1'b1;
   logic rx_a = 1'b1, ack_a = 1'b0, rx_b = 1'b1, ack_b = 1'b0;
   logic [7:0] data_a;
   logic [6:0] data_b;
   logic valid_a, perr_a, ferr_a, brk_a, ovr_a, busy_a;
   logic valid_b, perr_b, ferr_b, brk_b, ovr_b, busy_b;

   int checks = 0, errors = 0, lat = -1;

   always #10 clk = ~clk;

   uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
      .clk(clk), .rst(rst), .rx(rx_a), .rx_ack(ack_a), .rx_data(data_a), .rx_valid(valid_a),
      .parity_err(perr_a), .frame_err(ferr_a), .break_det(brk_a), .overrun_err(ovr_a), .busy(busy_a));

   uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_b (
      .clk(clk), .rst(rst), .rx(rx_b), .rx_ack(ack_b), .rx_data(data_b), .rx_valid(valid_b),
      .parity_err(perr_b), .frame_err(ferr_b), .break_det(brk_b), .overrun_err(ovr_b), .busy(busy_b));

   typedef struct {
      logic [7:0] d;
      logic       pb;
      logic       st;
      logic [7:0] e_data;
      logic       e_perr, e_ferr, e_brk;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic mk_frame(input logic [8:0] d, input int nb, input logic pb, input int ns,
                           input logic [1:0] st, output logic [15:0] fr, output int n);
      fr = '1;
      fr[0] = 1'b0;
      for (int i = 0; i < nb; i++) fr[1+i] = d[i];
      n = 1 + nb;
      fr[n] = pb;
      n++;
      for (int s = 0; s < ns; s++) begin
         fr[n] = st[s];
         n++;
      end
   endtask

   // Drives n bits of fr; optionally pulses ack at cycle ack_at of the last bit
   // and records the first cycle of the last bit on which rx_valid is seen high.
   task automatic send_bits(input int sel, input logic [15:0] fr, input int n, input int ack_at);
      lat = -1;
      for (int i = 0; i < n; i++) begin
         for (int c = 0; c < CPB; c++) begin
            if (sel == 0) rx_a = fr[i]; else rx_b = fr[i];
            if (i == n - 1 && c == ack_at) begin
               if (sel == 0) ack_a = 1'b1; else ack_b = 1'b1;
            end
            @(posedge clk); #1;
            ack_a = 1'b0;
            ack_b = 1'b0;
            if (i == n - 1 && lat < 0 && ((sel == 0) ? valid_a : valid_b)) lat = c;
         end
      end
      if (sel == 0) rx_a = 1'b1; else rx_b = 1'b1;
   endtask

   task automatic ack_pulse(input int sel);
      if (sel == 0) ack_a = 1'b1; else ack_b = 1'b1;
      @(posedge clk); #1;
      ack_a = 1'b0;
      ack_b = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int sel);
      for (int c = 0; c < 400 && ((sel == 0) ? busy_a : busy_b); c++) begin
         @(posedge clk); #1;
      end
      chk("wait_idle", (sel == 0) ? busy_a : busy_b, 1'b0);
   endtask

   task automatic send_a(input logic [7:0] d, input logic pb, input logic st, input int ack_at);
      logic [15:0] fr;
      int n;
      mk_frame({1'b0, d}, 8, pb, 1, {1'b1, st}, fr, n);
      send_bits(0, fr, n, ack_at);
   endtask

   initial begin
      #1500000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[7];
      logic [15:0] fr;
      int n, cal;
      bit seen;
      logic [7:0] d;
      logic pb, st, e_perr, e_ferr, e_brk, valid_m, ovr_m;

      tbl[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{8'h55, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0};
      tbl[3] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
      tbl[4] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
      tbl[5] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};

      rst = 1'b1;
      idle(3);
      chk("rst_valid", valid_a, 0);
      chk("rst_data", data_a, 0);
      chk("rst_perr", perr_a, 0);
      chk("rst_ferr", ferr_a, 0);
      chk("rst_brk", brk_a, 0);
      chk("rst_ovr", ovr_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_b_valid", valid_b, 0);
      rst = 1'b0;
      idle(2 * CPB);

      for (int i = 0; i < 7; i++) begin
         send_a(tbl[i].d, tbl[i].pb, tbl[i].st, -1);
         chk($sformatf("tbl%0d_valid", i), valid_a, 1);
         chk($sformatf("tbl%0d_data", i), data_a, tbl[i].e_data);
         chk($sformatf("tbl%0d_perr", i), perr_a, tbl[i].e_perr);
         chk($sformatf("tbl%0d_ferr", i), ferr_a, tbl[i].e_ferr);
         chk($sformatf("tbl%0d_brk", i), brk_a, tbl[i].e_brk);
         chk($sformatf("tbl%0d_ovr", i), ovr_a, 0);
         ack_pulse(0);
         chk($sformatf("tbl%0d_ack_valid", i), valid_a, 0);
         chk($sformatf("tbl%0d_ack_flags", i), {perr_a, ferr_a, brk_a}, 0);
         wait_idle(0);
         idle(2 * CPB);
      end

      // line held low for 12 bit times: one break report, ack mid-reception
      seen = 1'b0;
      rx_a = 1'b0;
      for (int c = 0; c < 12 * CPB; c++) begin
         @(posedge clk); #1;
         ack_a = 1'b0;
         if (valid_a && !seen) begin
            seen = 1'b1;
            chk("brk_data", data_a, 0);
            chk("brk_ferr", ferr_a, 1);
            chk("brk_det", brk_a, 1);
            ack_a = 1'b1;
         end
      end
      ack_a = 1'b0;
      chk("brk_seen", seen, 1);
      rx_a = 1'b1;
      wait_idle(0);
      ack_pulse(0);
      idle(2 * CPB);

      // back-to-back without ack -> overrun
      send_a(8'h11, 1'b0, 1'b1, -1);
      send_a(8'h22, 1'b0, 1'b1, -1);
      chk("ovr_data", data_a, 8'h22);
      chk("ovr_valid", valid_a, 1);
      chk("ovr_flag", ovr_a, 1);
      chk("ovr_perr", perr_a, 0);
      ack_pulse(0);
      chk("ovr_ack_valid", valid_a, 0);
      chk("ovr_ack_flag", ovr_a, 0);
      wait_idle(0);
      idle(2 * CPB);

      // ack on the completion cycle: completion wins, no overrun
      send_a(8'h5A, 1'b0, 1'b1, -1);
      cal = lat;
      chk("cal_lat_found", (cal >= 0), 1);
      wait_idle(0);
      idle(2 * CPB);
      send_a(8'h0F, 1'b0, 1'b1, cal);
      chk("coinc_valid", valid_a, 1);
      chk("coinc_data", data_a, 8'h0F);
      chk("coinc_ovr", ovr_a, 0);
      ack_pulse(0);
      chk("coinc_ack_valid", valid_a, 0);
      wait_idle(0);
      idle(2 * CPB);

      // glitch shorter than half a bit
      seen = 1'b0;
      rx_a = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         if (busy_a) seen = 1'b1;
      end
      rx_a = 1'b1;
      for (int c = 0; c < 3 * CPB; c++) begin
         @(posedge clk); #1;
         if (busy_a) seen = 1'b1;
      end
      chk("glitch_busy_seen", seen, 1);
      chk("glitch_busy_end", busy_a, 0);
      chk("glitch_valid", valid_a, 0);

      // reset in the middle of a frame, with a word already held
      send_a(8'h5A, 1'b0, 1'b1, -1);
      wait_idle(0);
      idle(CPB);
      mk_frame({1'b0, 8'hC3}, 8, 1'b0, 1, 2'b11, fr, n);
      send_bits(0, fr, 5, -1);
      rx_a = 1'b0;
      idle(CPB / 2);
      chk("pre_rst_busy", busy_a, 1);
      rst = 1'b1;
      #2;
      chk("mid_rst_valid", valid_a, 0);
      chk("mid_rst_data", data_a, 0);
      chk("mid_rst_busy", busy_a, 0);
      rx_a = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(2 * CPB);
      chk("post_rst_valid", valid_a, 0);
      send_a(8'hC3, 1'b0, 1'b1, -1);
      chk("post_rst_data", data_a, 8'hC3);
      chk("post_rst_flags", {valid_a, perr_a, ferr_a, ovr_a}, 4'b1000);
      ack_pulse(0);
      wait_idle(0);
      idle(CPB);

      // randomized frames against the frame-level model
      valid_m = 1'b0;
      ovr_m   = 1'b0;
      for (int k = 0; k < 24; k++) begin
         d  = 8'($urandom_range(0, 255));
         if (k % 6 == 0) d = 8'h00;
         pb = 1'($countones(d) % 2);
         if ($urandom_range(0, 3) == 0) pb = ~pb;
         st = ($urandom_range(0, 4) == 0) ? 1'b0 : 1'b1;
         e_perr = (($countones(d) + int'(pb)) % 2) != 0;
         e_ferr = !st;
         e_brk  = e_ferr && (d == 8'h00) && !pb;
         ovr_m  = ovr_m | valid_m;
         valid_m = 1'b1;
         send_a(d, pb, st, -1);
         chk($sformatf("rnd%0d_valid", k), valid_a, valid_m);
         chk($sformatf("rnd%0d_data", k), data_a, d);
         chk($sformatf("rnd%0d_perr", k), perr_a, e_perr);
         chk($sformatf("rnd%0d_ferr", k), ferr_a, e_ferr);
         chk($sformatf("rnd%0d_brk", k), brk_a, e_brk);
         chk($sformatf("rnd%0d_ovr", k), ovr_a, ovr_m);
         if ($urandom_range(0, 3) != 0) begin
            ack_pulse(0);
            valid_m = 1'b0;
            ovr_m   = 1'b0;
            chk($sformatf("rnd%0d_ack", k), {valid_a, ovr_a}, 0);
         end
         wait_idle(0);
         idle(CPB);
      end

      // 7 data bits, odd parity, two stop bits
      mk_frame({2'b00, 7'h41}, 7, 1'b1, 2, 2'b01, fr, n);
      send_bits(1, fr, n, -1);
      chk("b_valid", valid_b, 1);
      chk("b_data", data_b, 7'h41);
      chk("b_perr", perr_b, 0);
      chk("b_ferr", ferr_b, 1);
      chk("b_brk", brk_b, 0);
      ack_pulse(1);
      wait_idle(1);
      idle(2 * CPB);
      mk_frame({2'b00, 7'h41}, 7, 1'b0, 2, 2'b11, fr, n);
      send_bits(1, fr, n, -1);
      chk("b2_data", data_b, 7'h41);
      chk("b2_perr", perr_b, 1);
      chk("b2_ferr", ferr_b, 0);
      ack_pulse(1);
      wait_idle(1);
      idle(2 * CPB);
      mk_frame(9'h000, 7, 1'b1, 2, 2'b00, fr, n);
      send_bits(1, fr, n, -1);
      chk("b3_data", data_b, 0);
      chk("b3_flags", {perr_b, ferr_b, brk_b}, 3'b010);
      ack_pulse(1);
      chk("b3_ack", valid_b, 0);
      wait_idle(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
